// File: rtl/edge_line_ctrl.sv
// Line/frame sequencer around a sobel3x3 horizontal-gradient core: feeds pixels plus
// per-line flush beats, re-tags core results with position and buffers them for a ready/valid sink.
module edge_line_ctrl #(
  parameter int LINE_W   = 640,
  parameter int FRAME_H  = 480,
  parameter int CORE_LAT = 2,
  parameter int BORDER   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_vld,
  output logic        s_rdy,
  input  logic [7:0]  s_pix,
  input  logic        s_sof,
  input  logic        s_eol,
  output logic        core_vld,
  output logic [7:0]  core_pix,
  input  logic [7:0]  core_mag,
  output logic        m_vld,
  input  logic        m_rdy,
  output logic [7:0]  m_mag,
  output logic        m_sof,
  output logic        m_eol,
  output logic [15:0] line_cnt,
  output logic        err_len,
  output logic        err_frm
);
  localparam logic [15:0] LAST_COL  = 16'(LINE_W - 1);
  localparam logic [15:0] LAT       = 16'(CORE_LAT);
  localparam logic [15:0] ZLO       = 16'(CORE_LAT + BORDER);
  localparam logic [15:0] ZHI       = 16'(LINE_W - BORDER + CORE_LAT);
  localparam logic [15:0] LAST_LINE = 16'(FRAME_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_nx;

  logic        ready_q;
  logic [15:0] beat_idx, last_idx, cur_idx;
  logic [7:0]  last_pix;
  logic        pix_acc, pix_last, line_done;
  logic        cap_vld, cap_zero, cap_sof, cap_eol;
  logic [7:0]  cap_mag;
  logic [1:0]  occ;
  logic        rd_ptr, wr_ptr;
  logic [1:0][7:0] buf_mag;
  logic [1:0]  buf_sof, buf_eol;
  logic        pop, pop_buf, push, allow;

  // A beat is only allowed if its eventual capture is guaranteed a buffer slot.
  assign pop     = m_vld && m_rdy;
  assign pop_buf = pop && (occ != 2'd0);
  assign push    = cap_vld && !(pop && (occ == 2'd0));
  assign allow   = (({1'b0, occ} + {2'b00, cap_vld}) - {2'b00, pop}) < 3'd2;
  assign cap_mag = cap_zero ? 8'd0 : core_mag;

  always_comb begin
    state_nx  = state;
    s_rdy     = 1'b0;
    core_vld  = 1'b0;
    core_pix  = '0;
    pix_acc   = 1'b0;
    pix_last  = 1'b0;
    line_done = 1'b0;
    cur_idx   = (state == IDLE) ? 16'd0 : beat_idx;
    case (state)
      IDLE: begin
        // Non-sof pixels are swallowed; a sof pixel waits for buffer room.
        s_rdy   = ready_q && (allow || !s_sof);
        pix_acc = s_vld && s_rdy && s_sof;
      end
      RUN: begin
        s_rdy   = allow;
        pix_acc = s_vld && s_rdy;
      end
      FLUSH: begin
        core_vld  = allow;
        core_pix  = allow ? last_pix : 8'd0;
        line_done = allow && (beat_idx == last_idx);
        if (line_done) state_nx = (line_cnt == LAST_LINE) ? IDLE : RUN;
      end
      default: state_nx = IDLE;
    endcase
    if (pix_acc) begin
      core_vld = 1'b1;
      core_pix = s_pix;
      pix_last = s_eol || (cur_idx == LAST_COL);
      state_nx = pix_last ? FLUSH : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ready_q  <= 1'b0;
      beat_idx <= '0;
      last_idx <= '0;
      last_pix <= '0;
      line_cnt <= '0;
      err_len  <= 1'b0;
      err_frm  <= 1'b0;
      cap_vld  <= 1'b0;
      cap_zero <= 1'b0;
      cap_sof  <= 1'b0;
      cap_eol  <= 1'b0;
    end else begin
      state   <= state_nx;
      ready_q <= 1'b1;
      cap_vld <= core_vld && (cur_idx >= LAT);
      if (core_vld) begin
        cap_zero <= (cur_idx < ZLO) || (cur_idx >= ZHI);
        cap_sof  <= (cur_idx == LAT) && (line_cnt == 16'd0);
        cap_eol  <= (state == FLUSH) && (beat_idx == last_idx);
        beat_idx <= line_done ? 16'd0 : cur_idx + 16'd1;
      end
      if (pix_acc) begin
        last_pix <= s_pix;
        if (state == IDLE) begin
          err_len  <= 1'b0;
          err_frm  <= 1'b0;
          line_cnt <= '0;
        end else if (s_sof) begin
          err_frm <= 1'b1;
          if (cur_idx == 16'd0) line_cnt <= '0;
        end
        if (pix_last) begin
          last_idx <= cur_idx + LAT;
          if (!(s_eol && (cur_idx == LAST_COL))) err_len <= 1'b1;
        end
      end
      if (line_done) line_cnt <= line_cnt + 16'd1;
    end
  end

  // Two-entry result buffer; an empty buffer passes the capture straight through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ     <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      buf_mag <= '0;
      buf_sof <= '0;
      buf_eol <= '0;
    end else begin
      if (push) begin
        buf_mag[wr_ptr] <= cap_mag;
        buf_sof[wr_ptr] <= cap_sof;
        buf_eol[wr_ptr] <= cap_eol;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop_buf) rd_ptr <= ~rd_ptr;
      occ <= occ + 2'(push) - 2'(pop_buf);
    end
  end

  assign m_vld = (occ != 2'd0) || cap_vld;

  always_comb begin
    m_mag = '0;
    m_sof = 1'b0;
    m_eol = 1'b0;
    if (occ != 2'd0) begin
      m_mag = buf_mag[rd_ptr];
      m_sof = buf_sof[rd_ptr];
      m_eol = buf_eol[rd_ptr];
    end else if (cap_vld) begin
      m_mag = cap_mag;
      m_sof = cap_sof;
      m_eol = cap_eol;
    end
  end
endmodule

// File: tb/tb_edge_line_ctrl.sv
// Self-checking bench for edge_line_ctrl: a stand-in gradient core, randomized streams,
// and a frame/line reference model built from the line-splitting rules.
module tb_edge_line_ctrl;
  localparam int LW = 8;
  localparam int FH = 2;
  localparam int CL = 2;
  localparam int BD = 1;

  typedef struct packed {logic [7:0] pix; logic sof; logic eol;} beat_t;
  typedef struct packed {logic [7:0] mag; logic sof; logic eol;} res_t;

  logic        clk = 1'b0, rst_n;
  logic        s_vld, s_rdy, s_sof, s_eol;
  logic [7:0]  s_pix;
  logic        core_vld;
  logic [7:0]  core_pix, core_mag;
  logic        m_vld, m_rdy, m_sof, m_eol;
  logic [7:0]  m_mag;
  logic [15:0] line_cnt;
  logic        err_len, err_frm;

  edge_line_ctrl #(.LINE_W(LW), .FRAME_H(FH), .CORE_LAT(CL), .BORDER(BD)) dut (
    .clk(clk), .rst_n(rst_n), .s_vld(s_vld), .s_rdy(s_rdy), .s_pix(s_pix),
    .s_sof(s_sof), .s_eol(s_eol), .core_vld(core_vld), .core_pix(core_pix),
    .core_mag(core_mag), .m_vld(m_vld), .m_rdy(m_rdy), .m_mag(m_mag),
    .m_sof(m_sof), .m_eol(m_eol), .line_cnt(line_cnt), .err_len(err_len),
    .err_frm(err_frm));

  always #5 clk = ~clk;

  // Stand-in core: result after beat k is |x[k] - x[k-2]|, held while not enabled.
  logic [7:0] h0 = 8'd0, h1 = 8'd0, cm = 8'd0;
  always @(posedge clk) if (core_vld) begin
    h1 <= h0;
    h0 <= core_pix;
    cm <= (core_pix > h1) ? core_pix - h1 : h1 - core_pix;
  end
  assign core_mag = cm;

  int    tests = 0, fails = 0;
  int    cyc = 0, stall_cnt = 0, stab_err = 0, mv_cnt = 0;
  int    first_acc = -1, first_mv = -1;
  int    rdy_mode = 0, ph = 0;
  bit    hold = 1'b0;
  res_t  held;
  beat_t stim[$];
  res_t  exp_q[$], got[$];
  bit    exp_len, exp_frm;

  always @(posedge clk) cyc++;

  initial begin
    m_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: m_rdy = 1'b1;
        1: begin m_rdy = (ph == 0); ph = (ph + 1) % 3; end
        default: m_rdy = 1'($urandom_range(1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_vld && m_rdy) got.push_back({m_mag, m_sof, m_eol});
    if (m_vld) mv_cnt++;
    if (s_vld && !s_rdy && rst_n) stall_cnt++;
    if (s_vld && s_rdy && first_acc < 0) first_acc = cyc;
    if (m_vld && first_mv < 0) first_mv = cyc;
    if (hold && !(m_vld && res_t'({m_mag, m_sof, m_eol}) == held)) stab_err++;
    hold = m_vld && !m_rdy;
    held = {m_mag, m_sof, m_eol};
  end

  function automatic void add_line(int n, bit ramp, bit eol_end);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.pix = ramp ? 8'(i * 10) : 8'($urandom_range(255));
      b.sof = 1'b0;
      b.eol = eol_end && (i == n - 1);
      stim.push_back(b);
    end
  endfunction

  // Reference: split the stream into frames/lines by the sof/eol/length rules, then
  // compute each column from its own line's pixels plus two repeats of the last one.
  function automatic void model();
    logic [7:0] line[$];
    logic [7:0] a, b;
    res_t r;
    int lidx = 0, col = 0;
    bit active = 1'b0;
    for (int i = 0; i < stim.size(); i++) begin
      if (!active) begin
        if (!stim[i].sof) continue;
        active = 1'b1; lidx = 0; col = 0; exp_len = 1'b0; exp_frm = 1'b0;
      end else if (stim[i].sof) begin
        exp_frm = 1'b1;
        if (col == 0) lidx = 0;
      end
      line.push_back(stim[i].pix);
      col++;
      if (stim[i].eol || col == LW) begin
        if (!(stim[i].eol && col == LW)) exp_len = 1'b1;
        for (int c = 0; c < col; c++) begin
          a = (c + 2 < col) ? line[c + 2] : line[col - 1];
          b = line[c];
          r.mag = (c < BD || c >= LW - BD) ? 8'd0 : ((a > b) ? a - b : b - a);
          r.sof = (c == 0) && (lidx == 0);
          r.eol = (c == col - 1);
          exp_q.push_back(r);
        end
        line.delete();
        col = 0;
        lidx++;
        if (lidx == FH) active = 1'b0;
      end
    end
  endfunction

  task automatic drive_stim(int gap_pct);
    int t;
    foreach (stim[i]) begin
      if ($urandom_range(99) < gap_pct) begin s_vld = 1'b0; @(posedge clk); #1; end
      s_vld = 1'b1; s_pix = stim[i].pix; s_sof = stim[i].sof; s_eol = stim[i].eol;
      @(negedge clk);
      t = 0;
      while (!s_rdy && t < 500) begin @(negedge clk); t++; end
      tests++;
      if (t >= 500) begin fails++; $display("FAIL drive_timeout beat %0d s_rdy=%b required 1", i, s_rdy); end
      @(posedge clk); #1;
    end
    s_vld = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    int t = 0;
    while (got.size() < exp_q.size() && t < 3000) begin @(negedge clk); t++; end
    repeat (12) @(negedge clk);
    ok = (t < 3000);
    @(posedge clk); #1;
  endtask

  task automatic new_run();
    stim.delete(); exp_q.delete(); got.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_vld = 1'b0; s_pix = 8'h5a; s_sof = 1'b0; s_eol = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (s_rdy !== 1'b0)    begin fails++; $display("FAIL rst_s_rdy got %b exp 0", s_rdy); end
    tests++; if (core_vld !== 1'b0) begin fails++; $display("FAIL rst_core_vld got %b exp 0", core_vld); end
    tests++; if (core_pix !== 8'd0) begin fails++; $display("FAIL rst_core_pix got %h exp 0", core_pix); end
    tests++; if (m_vld !== 1'b0)    begin fails++; $display("FAIL rst_m_vld got %b exp 0", m_vld); end
    tests++; if ({m_sof, m_eol} !== 2'b00) begin fails++; $display("FAIL rst_m_flags got %b exp 00", {m_sof, m_eol}); end
    tests++; if (m_mag !== 8'd0)    begin fails++; $display("FAIL rst_m_mag got %h exp 0", m_mag); end
    tests++; if (line_cnt !== 16'd0) begin fails++; $display("FAIL rst_line_cnt got %0d exp 0", line_cnt); end
    tests++; if ({err_len, err_frm} !== 2'b00) begin fails++; $display("FAIL rst_err got %b exp 00", {err_len, err_frm}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    tests++; if (s_rdy !== 1'b1) begin fails++; $display("FAIL idle_s_rdy got %b exp 1", s_rdy); end
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    bit ok;
    new_run();
    rdy_mode = 0;
    add_line(LW, 1'b1, 1'b1); add_line(LW, 1'b1, 1'b1);
    stim[0].sof = 1'b1;
    model();
    stall_cnt = 0; first_acc = -1; first_mv = -1;
    drive_stim(0);
    wait_drain(ok);
    tests++; if (!ok) begin fails++; $display("FAIL stream_timeout got %0d results exp %0d", got.size(), exp_q.size()); end
    tests++; if (got.size() !== exp_q.size()) begin fails++; $display("FAIL stream_count got %0d exp %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      tests++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL stream_res[%0d] got %h exp %h", i, got[i], exp_q[i]); end
    end
    tests++; if (first_mv - first_acc !== 3) begin fails++; $display("FAIL stream_latency got %0d exp 3", first_mv - first_acc); end
    tests++; if (stall_cnt !== 2) begin fails++; $display("FAIL stream_stall got %0d exp 2", stall_cnt); end
    tests++; if (line_cnt !== 16'(FH)) begin fails++; $display("FAIL stream_line_cnt got %0d exp %0d", line_cnt, FH); end
    tests++; if ({err_len, err_frm} !== 2'b00) begin fails++; $display("FAIL stream_err got %b exp 00", {err_len, err_frm}); end
    @(negedge clk);
    tests++; if (s_rdy !== 1'b1) begin fails++; $display("FAIL stream_idle_rdy got %b exp 1", s_rdy); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bit ok;
    new_run();
    rdy_mode = 1; ph = 0; stab_err = 0;
    add_line(LW, 1'b0, 1'b1); add_line(LW, 1'b0, 1'b1);
    stim[0].sof = 1'b1;
    model();
    drive_stim(20);
    wait_drain(ok);
    rdy_mode = 0;
    tests++; if (!ok) begin fails++; $display("FAIL bp_timeout got %0d results exp %0d", got.size(), exp_q.size()); end
    tests++; if (got.size() !== exp_q.size()) begin fails++; $display("FAIL bp_count got %0d exp %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      tests++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL bp_res[%0d] got %h exp %h", i, got[i], exp_q[i]); end
    end
    tests++; if (stab_err !== 0) begin fails++; $display("FAIL bp_hold_stable got %0d changes exp 0", stab_err); end
  endtask

  task automatic test_short_line();
    bit ok;
    new_run();
    rdy_mode = 2;
    add_line(6, 1'b0, 1'b1); add_line(LW, 1'b0, 1'b1);
    stim[0].sof = 1'b1;
    model();
    drive_stim(30);
    wait_drain(ok);
    rdy_mode = 0;
    tests++; if (!ok) begin fails++; $display("FAIL short_timeout got %0d results exp %0d", got.size(), exp_q.size()); end
    tests++; if (got.size() !== exp_q.size()) begin fails++; $display("FAIL short_count got %0d exp %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      tests++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL short_res[%0d] got %h exp %h", i, got[i], exp_q[i]); end
    end
    tests++; if (err_len !== exp_len) begin fails++; $display("FAIL short_err_len got %b exp %b", err_len, exp_len); end
    tests++; if (line_cnt !== 16'(FH)) begin fails++; $display("FAIL short_line_cnt got %0d exp %0d", line_cnt, FH); end
  endtask

  task automatic test_long_line();
    bit ok;
    new_run();
    rdy_mode = 2;
    add_line(2 * LW, 1'b0, 1'b1);
    stim[0].sof = 1'b1;
    model();
    drive_stim(10);
    wait_drain(ok);
    rdy_mode = 0;
    tests++; if (!ok) begin fails++; $display("FAIL long_timeout got %0d results exp %0d", got.size(), exp_q.size()); end
    tests++; if (got.size() !== exp_q.size()) begin fails++; $display("FAIL long_count got %0d exp %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      tests++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL long_res[%0d] got %h exp %h", i, got[i], exp_q[i]); end
    end
    tests++; if (err_len !== exp_len) begin fails++; $display("FAIL long_err_len got %b exp %b", err_len, exp_len); end
  endtask

  task automatic test_mid_sof();
    bit ok;
    new_run();
    rdy_mode = 2;
    add_line(LW, 1'b0, 1'b1); add_line(LW, 1'b0, 1'b1); add_line(LW, 1'b0, 1'b1);
    stim[0].sof = 1'b1;
    stim[3].sof = 1'b1;
    stim[LW].sof = 1'b1;
    model();
    drive_stim(15);
    wait_drain(ok);
    rdy_mode = 0;
    tests++; if (!ok) begin fails++; $display("FAIL msof_timeout got %0d results exp %0d", got.size(), exp_q.size()); end
    tests++; if (got.size() !== exp_q.size()) begin fails++; $display("FAIL msof_count got %0d exp %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      tests++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL msof_res[%0d] got %h exp %h", i, got[i], exp_q[i]); end
    end
    tests++; if (err_frm !== exp_frm) begin fails++; $display("FAIL msof_err_frm got %b exp %b", err_frm, exp_frm); end
    tests++; if (err_len !== exp_len) begin fails++; $display("FAIL msof_err_len got %b exp %b", err_len, exp_len); end
    tests++; if (line_cnt !== 16'(FH)) begin fails++; $display("FAIL msof_line_cnt got %0d exp %0d", line_cnt, FH); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    new_run();
    rdy_mode = 0;
    add_line(4, 1'b0, 1'b0);
    stim[0].sof = 1'b1;
    drive_stim(0);
    s_vld = 1'b1; s_pix = 8'h77; s_sof = 1'b0; s_eol = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({s_rdy, core_vld, m_vld} !== 3'b000) begin fails++; $display("FAIL rmid_ctl got %b exp 000", {s_rdy, core_vld, m_vld}); end
    tests++; if ({core_pix, m_mag} !== 16'd0) begin fails++; $display("FAIL rmid_data got %h exp 0", {core_pix, m_mag}); end
    tests++; if (line_cnt !== 16'd0) begin fails++; $display("FAIL rmid_line_cnt got %0d exp 0", line_cnt); end
    s_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    new_run();
    add_line(LW, 1'b0, 1'b1);
    mv_cnt = 0;
    drive_stim(0);
    repeat (20) @(negedge clk);
    tests++; if (mv_cnt !== 0) begin fails++; $display("FAIL rmid_no_sof_out got %0d valid cycles exp 0", mv_cnt); end
    @(posedge clk); #1;
    new_run();
    add_line(LW, 1'b0, 1'b1); add_line(LW, 1'b0, 1'b1);
    stim[0].sof = 1'b1;
    model();
    drive_stim(0);
    wait_drain(ok);
    tests++; if (!ok) begin fails++; $display("FAIL rmid_timeout got %0d results exp %0d", got.size(), exp_q.size()); end
    tests++; if (got.size() !== exp_q.size()) begin fails++; $display("FAIL rmid_count got %0d exp %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      tests++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL rmid_res[%0d] got %h exp %h", i, got[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_short_line();
    test_long_line();
    test_mid_sof();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
